// File: rtl/calibration_sequencer.sv
// LED position calibration controller: steps through one bit-plane per LED-address
// bit, triggers one capture per plane, then scans the accumulator RAM and records
// the first pixel whose decoded code names each LED.
module calibration_sequencer #(
   parameter int unsigned NUM_LEDS       = 50,
   parameter int unsigned NUM_BITS       = 10,
   parameter int unsigned NUM_PIXELS     = 3600,
   parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
   input  logic                              clk_pixel,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              abort,
   output logic [$clog2(NUM_BITS)-1:0]       pattern_bit,
   output logic                              pattern_valid,
   output logic                              capture_start,
   input  logic                              capture_busy,
   output logic                              read_req,
   output logic [$clog2(NUM_PIXELS)-1:0]     read_addr,
   input  logic                              read_valid,
   input  logic [NUM_BITS-1:0]               read_data,
   output logic                              loc_we,
   output logic [$clog2(NUM_LEDS+1)-1:0]     loc_led,
   output logic [$clog2(NUM_PIXELS)-1:0]     loc_pixel,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   output logic [$clog2(NUM_LEDS+1)-1:0]     found_count
);

   localparam int unsigned BIT_W = $clog2(NUM_BITS);
   localparam int unsigned LED_W = $clog2(NUM_LEDS + 1);
   localparam int unsigned PIX_W = $clog2(NUM_PIXELS);
   localparam int unsigned CNT_W = $clog2(NUM_PIXELS + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIGGER,
      S_WAIT_BUSY,
      S_WAIT_IDLE,
      S_NEXT,
      S_SCAN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t               state;
   logic                 start_q;
   logic [NUM_LEDS-1:0]  found;
   logic [CNT_W-1:0]     rsp_cnt;
   logic [TO_W-1:0]      tcnt;

   logic                 start_edge_c;
   logic [NUM_LEDS-1:0]  code_hit_c;
   logic                 new_led_c;
   logic                 rsp_take_c;

   // Decode the returned code to a one-hot LED id; out-of-range codes match nothing
   always_comb begin
      start_edge_c = start & ~start_q;
      code_hit_c   = '0;
      for (int i = 0; i < int'(NUM_LEDS); i++) begin
         code_hit_c[i] = (read_data == NUM_BITS'(i + 1));
      end
      new_led_c  = |(code_hit_c & ~found);
      rsp_take_c = ((state == S_SCAN) || (state == S_DRAIN)) && read_valid &&
                   (rsp_cnt < CNT_W'(NUM_PIXELS));
   end

   // Sequencer state, response bookkeeping and registered outputs
   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         start_q       <= 1'b0;
         found         <= '0;
         rsp_cnt       <= '0;
         tcnt          <= '0;
         pattern_bit   <= '0;
         pattern_valid <= 1'b0;
         capture_start <= 1'b0;
         read_req      <= 1'b0;
         read_addr     <= '0;
         loc_we        <= 1'b0;
         loc_led       <= '0;
         loc_pixel     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         found_count   <= '0;
      end else begin
         start_q       <= start;
         capture_start <= 1'b0;
         loc_we        <= 1'b0;

         // Responses arrive in request order, so the response count is the pixel address
         if (rsp_take_c) begin
            rsp_cnt <= rsp_cnt + CNT_W'(1);
            if (new_led_c) begin
               loc_we      <= 1'b1;
               loc_led     <= LED_W'(read_data);
               loc_pixel   <= PIX_W'(rsp_cnt);
               found       <= found | code_hit_c;
               found_count <= found_count + LED_W'(1);
            end
         end

         if (abort) begin
            state         <= S_IDLE;
            pattern_valid <= 1'b0;
            capture_start <= 1'b0;
            read_req      <= 1'b0;
            loc_we        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE: begin
                  if (start_edge_c) begin
                     state         <= S_TRIGGER;
                     pattern_bit   <= '0;
                     found         <= '0;
                     found_count   <= '0;
                     error         <= 1'b0;
                     pattern_valid <= 1'b1;
                     capture_start <= 1'b1;
                     busy          <= 1'b1;
                     done          <= 1'b0;
                  end
               end
               S_TRIGGER: begin
                  tcnt  <= '0;
                  state <= S_WAIT_BUSY;
               end
               S_WAIT_BUSY, S_WAIT_IDLE: begin
                  // One timeout window covers both waits of a capture
                  if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                     state         <= S_DONE;
                     error         <= 1'b1;
                     pattern_valid <= 1'b0;
                     busy          <= 1'b0;
                     done          <= 1'b1;
                  end else begin
                     tcnt <= tcnt + TO_W'(1);
                     if ((state == S_WAIT_BUSY) && capture_busy) begin
                        state <= S_WAIT_IDLE;
                     end else if ((state == S_WAIT_IDLE) && !capture_busy) begin
                        state <= S_NEXT;
                     end
                  end
               end
               S_NEXT: begin
                  if (pattern_bit == BIT_W'(NUM_BITS - 1)) begin
                     state         <= S_SCAN;
                     pattern_valid <= 1'b0;
                     read_req      <= 1'b1;
                     read_addr     <= '0;
                     rsp_cnt       <= '0;
                  end else begin
                     state         <= S_TRIGGER;
                     pattern_bit   <= pattern_bit + BIT_W'(1);
                     capture_start <= 1'b1;
                  end
               end
               S_SCAN: begin
                  if (read_addr == PIX_W'(NUM_PIXELS - 1)) begin
                     state    <= S_DRAIN;
                     read_req <= 1'b0;
                  end else begin
                     read_addr <= read_addr + PIX_W'(1);
                  end
               end
               S_DRAIN: begin
                  if (rsp_cnt == CNT_W'(NUM_PIXELS)) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_calibration_sequencer.sv
// Scoreboard bench for calibration_sequencer with capture-FSM and accumulator models.
module tb_calibration_sequencer;

   localparam int unsigned NL  = 5;
   localparam int unsigned NB  = 4;
   localparam int unsigned NP  = 16;
   localparam int unsigned TO  = 100;
   localparam int unsigned LAT = 3;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      start = 1'b0;
   logic                      abort = 1'b0;
   logic [$clog2(NB)-1:0]     pattern_bit;
   logic                      pattern_valid;
   logic                      capture_start;
   logic                      capture_busy;
   logic                      read_req;
   logic [$clog2(NP)-1:0]     read_addr;
   logic                      read_valid;
   logic [NB-1:0]             read_data;
   logic                      loc_we;
   logic [$clog2(NL+1)-1:0]   loc_led;
   logic [$clog2(NP)-1:0]     loc_pixel;
   logic                      busy;
   logic                      done;
   logic                      error;
   logic [$clog2(NL+1)-1:0]   found_count;

   int checks = 0;
   int errors = 0;

   int exp_bit_q[$];
   int exp_addr_q[$];
   int exp_led_q[$];
   int exp_pix_q[$];
   int exp_found = 0;

   calibration_sequencer #(
      .NUM_LEDS(NL), .NUM_BITS(NB), .NUM_PIXELS(NP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_pixel(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .pattern_bit(pattern_bit), .pattern_valid(pattern_valid),
      .capture_start(capture_start), .capture_busy(capture_busy),
      .read_req(read_req), .read_addr(read_addr), .read_valid(read_valid),
      .read_data(read_data), .loc_we(loc_we), .loc_led(loc_led),
      .loc_pixel(loc_pixel), .busy(busy), .done(done), .error(error),
      .found_count(found_count)
   );

   always #5 clk = ~clk;

   // Capture FSM model: busy for busy_len cycles, starting busy_dly cycles after the pulse
   int cap_t = 0;
   int busy_dly = 3;
   int busy_len = 20;
   bit no_busy = 1'b0;
   always @(posedge clk) begin
      if (capture_start && !no_busy) cap_t <= 1;
      else if (cap_t != 0) cap_t <= (cap_t >= busy_dly + busy_len) ? 0 : cap_t + 1;
   end
   assign capture_busy = (cap_t > busy_dly) && (cap_t <= busy_dly + busy_len);

   // Accumulator model: fixed-latency, in-order read pipeline
   logic [NB-1:0]          mem [NP];
   logic [LAT-1:0]         v_pipe = '0;
   logic [$clog2(NP)-1:0]  a_pipe [LAT];
   always @(posedge clk) begin
      v_pipe    <= {v_pipe[LAT-2:0], read_req};
      a_pipe[0] <= read_addr;
      for (int i = 1; i < int'(LAT); i++) a_pipe[i] <= a_pipe[i-1];
   end
   assign read_valid = v_pipe[LAT-1];
   assign read_data  = mem[a_pipe[LAT-1]];

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int all_outs();
      return int'({pattern_bit, pattern_valid, capture_start, read_req, read_addr,
                   loc_we, loc_led, loc_pixel, busy, done, error, found_count});
   endfunction

   // Monitor: pop the scoreboard whenever the DUT presents an output event
   always @(negedge clk) begin
      if (rst_n) begin
         if (capture_start) begin
            if (exp_bit_q.size() == 0) check("capture_start_unexpected", int'(capture_start), 0);
            else check("pattern_bit", int'(pattern_bit), exp_bit_q.pop_front());
            check("pattern_valid_at_trigger", int'(pattern_valid), 1);
         end
         if (read_req) begin
            if (exp_addr_q.size() == 0) check("read_req_unexpected", int'(read_req), 0);
            else check("read_addr", int'(read_addr), exp_addr_q.pop_front());
            check("pattern_valid_in_scan", int'(pattern_valid), 0);
         end
         if (loc_we) begin
            if (exp_led_q.size() == 0) check("loc_we_unexpected", int'(loc_we), 0);
            else begin
               check("loc_led", int'(loc_led), exp_led_q.pop_front());
               check("loc_pixel", int'(loc_pixel), exp_pix_q.pop_front());
            end
         end
      end
   end

   // Reference model: every plane once, every address once, first pixel per valid id
   task automatic load_expect();
      bit seen [NL+1];
      int c;
      foreach (seen[i]) seen[i] = 1'b0;
      exp_found = 0;
      for (int b = 0; b < int'(NB); b++) exp_bit_q.push_back(b);
      for (int p = 0; p < int'(NP); p++) begin
         exp_addr_q.push_back(p);
         c = int'(mem[p]);
         if (c >= 1 && c <= int'(NL) && !seen[c]) begin
            seen[c] = 1'b1;
            exp_led_q.push_back(c);
            exp_pix_q.push_back(p);
            exp_found++;
         end
      end
   endtask

   task automatic clear_mem();
      for (int p = 0; p < int'(NP); p++) mem[p] = '0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic run_cal(input string tag);
      int n;
      load_expect();
      pulse_start();
      repeat (14) @(negedge clk);
      check({tag, "_busy_mid_run"}, int'(busy), 1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      n = 0;
      while (!done && n < 3000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_error"}, int'(error), 0);
      check({tag, "_busy_end"}, int'(busy), 0);
      check({tag, "_found_count"}, int'(found_count), exp_found);
      check({tag, "_planes_left"}, exp_bit_q.size(), 0);
      check({tag, "_reads_left"}, exp_addr_q.size(), 0);
      check({tag, "_locs_left"}, exp_led_q.size(), 0);
   endtask

   task automatic randomize_mem();
      for (int p = 0; p < int'(NP); p++)
         mem[p] = ($urandom_range(0, 1) == 1) ? NB'($urandom_range(1, NL))
                                              : NB'($urandom_range(0, 15));
   endtask

   initial begin
      int n;
      clear_mem();
      for (int i = 0; i < int'(LAT); i++) a_pipe[i] = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Duplicate code: only the first pixel is recorded
      clear_mem();
      mem[7] = NB'(3);
      mem[9] = NB'(3);
      run_cal("dup_code");

      // Out-of-range codes ignored
      clear_mem();
      mem[2] = NB'(6); mem[4] = NB'(15); mem[8] = NB'(6);
      mem[12] = NB'(5); mem[14] = NB'(15);
      run_cal("range");

      for (int r = 0; r < 6; r++) begin
         randomize_mem();
         busy_dly = $urandom_range(0, 4);
         busy_len = $urandom_range(1, 25);
         run_cal($sformatf("rand%0d", r));
      end
      busy_dly = 3;
      busy_len = 20;

      // Capture never goes busy: timeout, no scan
      no_busy = 1'b1;
      exp_bit_q.push_back(0);
      pulse_start();
      n = 0;
      while (!capture_start && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("timeout_trigger_seen", int'(capture_start), 1);
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("timeout_latency", n, 101);
      check("timeout_error", int'(error), 1);
      check("timeout_done", int'(done), 1);
      check("timeout_busy", int'(busy), 0);
      check("timeout_pattern_valid", int'(pattern_valid), 0);
      check("timeout_found_count", int'(found_count), 0);
      check("timeout_planes_left", exp_bit_q.size(), 0);
      no_busy = 1'b0;
      repeat (3) @(negedge clk);

      randomize_mem();
      run_cal("after_timeout");

      // Abort mid-scan: nothing more written although responses still arrive
      clear_mem();
      mem[3] = NB'(2);
      mem[4] = NB'(4);
      for (int b = 0; b < int'(NB); b++) exp_bit_q.push_back(b);
      for (int p = 0; p < 5; p++) exp_addr_q.push_back(p);
      pulse_start();
      n = 0;
      while (!(read_req && read_addr == 4) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_scan", int'(read_req), 1);
      abort = 1'b1;
      @(negedge clk);
      check("abort_busy", int'(busy), 0);
      check("abort_read_req", int'(read_req), 0);
      check("abort_done", int'(done), 0);
      check("abort_error", int'(error), 0);
      abort = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_reads_left", exp_addr_q.size(), 0);
      check("abort_locs_left", exp_led_q.size(), 0);

      // Asynchronous reset mid-WAIT_IDLE
      randomize_mem();
      for (int b = 0; b < int'(NB); b++) exp_bit_q.push_back(b);
      pulse_start();
      n = 0;
      while (!(pattern_bit == 1 && capture_busy) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("reset_reached_plane1", int'(capture_busy), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", all_outs(), 0);
      exp_bit_q.delete();
      exp_addr_q.delete();
      exp_led_q.delete();
      exp_pix_q.delete();
      repeat (40) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_cal("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/calibration_sequencer.md
Name: calibration_sequencer

Overview:
Top-level controller for LED position calibration. It steps through one bit-plane per LED-address bit. For each plane it selects the strand pattern, triggers one capture in the per-pixel shift-accumulate calibration FSM, and waits for that capture to finish. After the last plane it scans the accumulator RAM, decodes each pixel's code to an LED id, and writes the first pixel found per LED into the LED-position table.

Parameters:
NUM_LEDS, 50, number of LEDs on the strand; valid decoded ids are 1..NUM_LEDS.
NUM_BITS, 10, bit-planes per calibration; equals accumulator word width.
NUM_PIXELS, 3600, accumulator depth (downsampled pixels).
TIMEOUT_CYCLES, 50000000, maximum cycles per capture before error.

Ports:
clk_pixel  in  1  pixel clock, the only clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  rising edge begins calibration; ignored unless in IDLE or DONE.
abort  in  1  level; forces IDLE next cycle from any state.
pattern_bit  out  $clog2(NUM_BITS)  current bit-plane index b; LED i is lit iff bit b of (i+1) is 1.
pattern_valid  out  1  high while a bit-plane is being shown or captured.
capture_start  out  1  one-cycle pulse to the calibration FSM increment input.
capture_busy  in  1  high while the calibration FSM is out of its IDLE state.
read_req  out  1  accumulator read request, one per cycle.
read_addr  out  $clog2(NUM_PIXELS)  accumulator pixel address.
read_valid  in  1  read response valid; responses return in request order at any fixed latency.
read_data  in  NUM_BITS  accumulated code for the pixel.
loc_we  out  1  position-table write strobe.
loc_led  out  $clog2(NUM_LEDS+1)  LED id written (1-based).
loc_pixel  out  $clog2(NUM_PIXELS)  pixel address of that LED.
busy  out  1  high in all states except IDLE and DONE.
done  out  1  high in DONE.
error  out  1  capture timeout occurred; sticky until the next start.
found_count  out  $clog2(NUM_LEDS+1)  number of distinct LEDs located.

Behaviour:
- Reset: all outputs 0; state IDLE; the found bitmap (NUM_LEDS bits) is cleared.
- Start detection: start edge = start && !start_q; start_q is registered.
- States and transitions:
  - IDLE: on start edge, bit=0, clear the found bitmap, found_count=0, error=0, go to TRIGGER.
  - TRIGGER: pattern_valid=1; assert capture_start for exactly 1 cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for capture_busy=1, then go to WAIT_IDLE.
  - WAIT_IDLE: wait for capture_busy=0, then go to NEXT.
  - NEXT: if bit==NUM_BITS-1, go to SCAN with read counter reset; else bit++ and go to TRIGGER.
  - SCAN: read_req=1 every cycle with read_addr=req_cnt; go to DRAIN after issuing address NUM_PIXELS-1.
  - DRAIN: wait until the response counter reaches NUM_PIXELS, then go to DONE.
  - DONE: done=1; a start edge restarts exactly as from IDLE.
- Timeout: a single counter spans WAIT_BUSY plus WAIT_IDLE and restarts at each TRIGGER. Reaching TIMEOUT_CYCLES-1 sets error=1, deasserts pattern_valid and goes to DONE without scanning.
- Response handling: valid in SCAN and DRAIN. Each read_valid increments the response counter, which is the pixel address of that response.
  - code=read_data. If 1<=code<=NUM_LEDS and found[code-1]==0: loc_we=1, loc_led=code, loc_pixel=response counter, set found[code-1], found_count++.
  - Codes 0 and codes greater than NUM_LEDS are ignored.
  - Registered output: loc_* are valid 1 cycle after read_valid.
- Pattern timing: pattern_valid is high from TRIGGER through NEXT; it is low during SCAN, DRAIN and DONE.
- Abort:
  - Takes priority over every other transition.
  - No loc_we is issued after the cycle in which abort is sampled.
  - error is unchanged; done=0.
- start during busy is ignored. A start edge and abort in the same cycle resolve to abort.
- Counter widths are wide enough that the compare against NUM_PIXELS never wraps.

Test Plan:
1. Model FSM (busy for 20 cycles, starting 3 cycles after capture_start) with NUM_BITS=4, NUM_LEDS=5, NUM_PIXELS=16. Pulse start → 4 capture_start pulses with pattern_bit 0,1,2,3, then 16 read_req with addr 0..15, then done=1.
2. Accumulator model returning code=3 at pixel 7 and code=3 at pixel 9 → exactly one loc_we with loc_led=3, loc_pixel=7; found_count=1.
3. Codes 0, 6 and 15 at various pixels plus code 5 at pixel 12 → only loc_led=5, loc_pixel=12 is written; found_count=1.
4. Model never raises capture_busy, TIMEOUT_CYCLES=100 → error=1 and done=1 about 101 cycles after capture_start; no read_req is ever issued.
5. Assert abort mid-SCAN → state IDLE next cycle, read_req=0 and busy=0; no further loc_we even though responses are still arriving.
6. Drop rst_n asynchronously mid-WAIT_IDLE → all outputs 0 immediately; after release, a start edge runs a full calibration from bit 0.
